// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width, default data width and
// a register-number decoder used by the scoreboard.
package cpu_pkg;

   localparam int unsigned REG_AW   = 5;
   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_MAX = 2 ** REG_AW;

   function automatic logic [NREG_MAX-1:0] onehot_dec(input logic [REG_AW-1:0] i_addr);
      logic [NREG_MAX-1:0] w_oh;
      w_oh         = '0;
      w_oh[i_addr] = 1'b1;
      return w_oh;
   endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// One source operand: priority select (r0, forwarding channels, long-op writeback,
// regfile) plus the load-use and pending-long-op hazard flags for that source.
module operand_fwd_mux
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned NFWD = 2
) (
   input  logic [REG_AW-1:0]      i_src,
   input  logic                   i_used,
   input  logic [XLEN-1:0]        i_rf_rdata,
   input  logic                   i_busy,
   input  logic [NFWD-1:0]        i_fwd_valid,
   input  logic [NFWD-1:0]        i_fwd_ready,
   input  logic [NFWD*REG_AW-1:0] i_fwd_dest,
   input  logic [NFWD*XLEN-1:0]   i_fwd_data,
   input  logic                   i_wbl_valid,
   input  logic [REG_AW-1:0]      i_wbl_dest,
   input  logic [XLEN-1:0]        i_wbl_data,
   output logic [XLEN-1:0]        o_value,
   output logic                   o_stall_load,
   output logic                   o_stall_long
);

   logic w_hit;
   logic w_hit_ready;
   logic w_wbl_match;
   logic w_active;

   always_comb begin
      o_value     = i_rf_rdata;
      w_hit       = 1'b0;
      w_hit_ready = 1'b1;
      w_wbl_match = i_wbl_valid && (i_wbl_dest == i_src);
      if (w_wbl_match) begin
         o_value = i_wbl_data;
      end
      // Walk oldest to youngest so the lowest-index (youngest) match is left standing.
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (i_fwd_valid[k] && (i_fwd_dest[k*REG_AW +: REG_AW] == i_src)) begin
            o_value     = i_fwd_data[k*XLEN +: XLEN];
            w_hit       = 1'b1;
            w_hit_ready = i_fwd_ready[k];
         end
      end
      if (i_src == '0) begin
         o_value = '0;
         w_hit   = 1'b0;
      end
      w_active     = i_used && (i_src != '0);
      o_stall_load = w_active && w_hit && !w_hit_ready;
      o_stall_long = w_active && i_busy && !w_wbl_match && !w_hit;
   end

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode-stage operand read and hazard detection: per-source forwarding muxes,
// the long-op scoreboard, the outstanding long-op counter and the stall OR.
module decode_hazard_unit
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREG     = 32,
   parameter int unsigned NSRC     = 2,
   parameter int unsigned NFWD     = 2,
   parameter int unsigned MAX_LONG = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NSRC*REG_AW-1:0]         i_src_addr,
   input  logic [NSRC-1:0]                i_src_used,
   input  logic [NSRC*XLEN-1:0]           i_rf_rdata,
   input  logic [REG_AW-1:0]              i_dst_addr,
   input  logic                           i_dst_we,
   input  logic                           i_dst_long,
   input  logic                           i_issue,
   input  logic                           i_flush,
   input  logic [NFWD-1:0]                i_fwd_valid,
   input  logic [NFWD-1:0]                i_fwd_ready,
   input  logic [NFWD*REG_AW-1:0]         i_fwd_dest,
   input  logic [NFWD*XLEN-1:0]           i_fwd_data,
   input  logic                           i_wbl_valid,
   input  logic [REG_AW-1:0]              i_wbl_dest,
   input  logic [XLEN-1:0]                i_wbl_data,
   output logic [NSRC*XLEN-1:0]           o_src_value,
   output logic                           o_stall,
   output logic [NREG-1:0]                o_sb_busy,
   output logic [$clog2(MAX_LONG+1)-1:0]  o_long_cnt
);

   localparam int unsigned CW = $clog2(MAX_LONG + 1);

   logic [NREG-1:0]     r_sb_busy;
   logic [CW-1:0]       r_long_cnt;
   logic [NREG-1:0]     w_sb_nxt;
   logic [CW-1:0]       w_long_cnt_nxt;
   logic [NREG_MAX-1:0] w_set_oh;
   logic [NREG_MAX-1:0] w_clr_oh;
   logic [NSRC-1:0]     w_stall_load;
   logic [NSRC-1:0]     w_stall_long;
   logic                w_set;
   logic                w_waw;
   logic                w_full;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      operand_fwd_mux #(
         .XLEN (XLEN),
         .NFWD (NFWD)
      ) u_mux (
         .i_src        (i_src_addr[i*REG_AW +: REG_AW]),
         .i_used       (i_src_used[i]),
         .i_rf_rdata   (i_rf_rdata[i*XLEN +: XLEN]),
         .i_busy       (r_sb_busy[i_src_addr[i*REG_AW +: REG_AW]]),
         .i_fwd_valid  (i_fwd_valid),
         .i_fwd_ready  (i_fwd_ready),
         .i_fwd_dest   (i_fwd_dest),
         .i_fwd_data   (i_fwd_data),
         .i_wbl_valid  (i_wbl_valid),
         .i_wbl_dest   (i_wbl_dest),
         .i_wbl_data   (i_wbl_data),
         .o_value      (o_src_value[i*XLEN +: XLEN]),
         .o_stall_load (w_stall_load[i]),
         .o_stall_long (w_stall_long[i])
      );
   end

   always_comb begin
      w_set  = i_issue && !i_flush && i_dst_we && i_dst_long;
      w_waw  = i_dst_we && (i_dst_addr != '0) && r_sb_busy[i_dst_addr] &&
               !(i_wbl_valid && (i_wbl_dest == i_dst_addr));
      w_full = i_dst_long && (r_long_cnt == CW'(MAX_LONG)) && !i_wbl_valid;
      o_stall = !i_flush && ((|w_stall_load) || (|w_stall_long) || w_waw || w_full);
   end

   // Clear before set so a same-cycle set of the same register wins.
   always_comb begin
      w_set_oh = onehot_dec(i_dst_addr);
      w_clr_oh = onehot_dec(i_wbl_dest);
      w_sb_nxt = r_sb_busy;
      if (i_wbl_valid) begin
         w_sb_nxt = w_sb_nxt & ~w_clr_oh[NREG-1:0];
      end
      if (w_set && (i_dst_addr != '0)) begin
         w_sb_nxt = w_sb_nxt | w_set_oh[NREG-1:0];
      end
      w_sb_nxt[0] = 1'b0;
   end

   always_comb begin
      w_long_cnt_nxt = r_long_cnt;
      case ({w_set, i_wbl_valid})
         2'b10:   w_long_cnt_nxt = r_long_cnt + CW'(1);
         2'b01:   w_long_cnt_nxt = r_long_cnt - CW'(1);
         default: w_long_cnt_nxt = r_long_cnt;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sb_busy  <= '0;
         r_long_cnt <= '0;
      end else begin
         r_sb_busy  <= w_sb_nxt;
         r_long_cnt <= w_long_cnt_nxt;
      end
   end

   assign o_sb_busy  = r_sb_busy;
   assign o_long_cnt = r_long_cnt;

   a_cnt_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_set && !i_wbl_valid && (r_long_cnt == CW'(MAX_LONG))));
   a_cnt_no_underflow : assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_wbl_valid && !w_set && (r_long_cnt == '0)));

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Bench for decode_hazard_unit: directed scenarios plus random traffic, all checked
// against a behavioural model of the operand-select, stall and scoreboard rules.
module tb_decode_hazard_unit;

   localparam int NSRC     = 2;
   localparam int NFWD     = 2;
   localparam int MAX_LONG = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  src_addr;
   logic [1:0]  src_used;
   logic [63:0] rf_rdata;
   logic [4:0]  dst_addr;
   logic        dst_we, dst_long, issue, flush;
   logic [1:0]  fwd_valid, fwd_ready;
   logic [9:0]  fwd_dest;
   logic [63:0] fwd_data;
   logic        wbl_valid;
   logic [4:0]  wbl_dest;
   logic [31:0] wbl_data;
   logic [63:0] src_value;
   logic        stall;
   logic [31:0] sb_busy;
   logic [2:0]  long_cnt;

   int          n_total = 0;
   int          n_bad   = 0;

   logic [31:0] m_busy;
   int          m_cnt;
   int          m_q[$];

   always #5 clk = ~clk;

   decode_hazard_unit #(
      .XLEN     (32),
      .NREG     (32),
      .NSRC     (NSRC),
      .NFWD     (NFWD),
      .MAX_LONG (MAX_LONG)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_src_addr  (src_addr),
      .i_src_used  (src_used),
      .i_rf_rdata  (rf_rdata),
      .i_dst_addr  (dst_addr),
      .i_dst_we    (dst_we),
      .i_dst_long  (dst_long),
      .i_issue     (issue),
      .i_flush     (flush),
      .i_fwd_valid (fwd_valid),
      .i_fwd_ready (fwd_ready),
      .i_fwd_dest  (fwd_dest),
      .i_fwd_data  (fwd_data),
      .i_wbl_valid (wbl_valid),
      .i_wbl_dest  (wbl_dest),
      .i_wbl_data  (wbl_data),
      .o_src_value (src_value),
      .o_stall     (stall),
      .o_sb_busy   (sb_busy),
      .o_long_cnt  (long_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_value(input int i);
      logic [4:0] s;
      s = src_addr[i*5 +: 5];
      if (s == 0) return 32'h0;
      for (int k = 0; k < NFWD; k++)
         if (fwd_valid[k] && fwd_dest[k*5 +: 5] == s) return fwd_data[k*32 +: 32];
      if (wbl_valid && wbl_dest == s) return wbl_data;
      return rf_rdata[i*32 +: 32];
   endfunction

   function automatic logic m_stall();
      logic st;
      st = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         logic [4:0] s;
         int         hit;
         s   = src_addr[i*5 +: 5];
         hit = -1;
         if (src_used[i] && s != 0) begin
            for (int k = 0; k < NFWD; k++)
               if (hit < 0 && fwd_valid[k] && fwd_dest[k*5 +: 5] == s) hit = k;
            if (hit >= 0) begin
               if (!fwd_ready[hit]) st = 1'b1;
            end else if (m_busy[s] && !(wbl_valid && wbl_dest == s)) begin
               st = 1'b1;
            end
         end
      end
      if (dst_we && dst_addr != 0 && m_busy[dst_addr] && !(wbl_valid && wbl_dest == dst_addr))
         st = 1'b1;
      if (dst_long && m_cnt == MAX_LONG && !wbl_valid) st = 1'b1;
      if (flush) st = 1'b0;
      return st;
   endfunction

   task automatic model_reset();
      m_busy = '0;
      m_cnt  = 0;
      m_q.delete();
   endtask

   // Compare all outputs against the model, advance the model, then move to the next negedge.
   task automatic cyc(input string tag);
      logic [63:0] ev;
      logic        set;
      int          idx;
      for (int i = 0; i < NSRC; i++) ev[i*32 +: 32] = m_value(i);
      check_eq({tag, ".val"},   src_value, ev);
      check_eq({tag, ".stall"}, stall,     m_stall());
      check_eq({tag, ".sb"},    sb_busy,   m_busy);
      check_eq({tag, ".cnt"},   long_cnt,  m_cnt);
      set = issue && !flush && dst_we && dst_long;
      if (wbl_valid) begin
         m_busy[wbl_dest] = 1'b0;
         m_cnt--;
         idx = -1;
         foreach (m_q[j]) if (idx < 0 && m_q[j] == wbl_dest) idx = j;
         if (idx >= 0) m_q.delete(idx);
         else if (m_q.size() > 0) m_q.delete(0);
      end
      if (set) begin
         if (dst_addr != 0) m_busy[dst_addr] = 1'b1;
         m_cnt++;
         m_q.push_back(int'(dst_addr));
      end
      m_busy[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      src_addr  = '0;
      src_used  = '0;
      rf_rdata  = {32'h2222_2222, 32'h1111_1111};
      dst_addr  = '0;
      dst_we    = 1'b0;
      dst_long  = 1'b0;
      issue     = 1'b0;
      flush     = 1'b0;
      fwd_valid = '0;
      fwd_ready = '0;
      fwd_dest  = '0;
      fwd_data  = '0;
      wbl_valid = 1'b0;
      wbl_dest  = '0;
      wbl_data  = '0;
   endtask

   task automatic issue_long(input logic [4:0] d, input string tag);
      idle();
      dst_addr = d;
      dst_we   = 1'b1;
      dst_long = 1'b1;
      issue    = 1'b1;
      #1;
      cyc(tag);
   endtask

   task automatic wb_long(input logic [4:0] d, input logic [31:0] v, input string tag);
      idle();
      wbl_valid = 1'b1;
      wbl_dest  = d;
      wbl_data  = v;
      #1;
      cyc(tag);
   endtask

   initial begin
      idle();
      model_reset();
      rst = 1'b1;
      #1;
      check_eq("rst.sb", sb_busy, 0);
      check_eq("rst.cnt", long_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      // Forwarding priority and r0.
      src_addr[4:0] = 5'd5;
      src_used      = 2'b01;
      fwd_valid     = 2'b11;
      fwd_ready     = 2'b11;
      fwd_dest      = {5'd5, 5'd5};
      fwd_data      = {32'h0000_BBBB, 32'h0000_AAAA};
      rf_rdata[31:0] = 32'h1;
      #1;
      check_eq("fwd.young", src_value[31:0], 32'hAAAA);
      cyc("fwd.young");
      fwd_valid = 2'b10;
      #1;
      check_eq("fwd.old", src_value[31:0], 32'hBBBB);
      cyc("fwd.old");
      src_addr[4:0] = 5'd0;
      fwd_valid     = 2'b11;
      fwd_dest      = {5'd0, 5'd0};
      #1;
      check_eq("fwd.r0", src_value[31:0], 32'h0);
      cyc("fwd.r0");

      // Load-use.
      idle();
      fwd_valid     = 2'b01;
      fwd_dest[4:0] = 5'd3;
      src_addr[9:5] = 5'd3;
      src_used      = 2'b10;
      #1;
      check_eq("lu.used", stall, 1);
      cyc("lu.used");
      src_used = 2'b00;
      #1;
      check_eq("lu.unused", stall, 0);
      cyc("lu.unused");

      // Long op to r7, reader stalls until writeback.
      issue_long(5'd7, "long.iss");
      idle();
      src_addr[4:0] = 5'd7;
      src_used      = 2'b01;
      #1;
      check_eq("long.sb7", sb_busy[7], 1);
      check_eq("long.cnt", long_cnt, 1);
      check_eq("long.stall", stall, 1);
      cyc("long.wait");
      wbl_valid = 1'b1;
      wbl_dest  = 5'd7;
      wbl_data  = 32'h55;
      #1;
      check_eq("long.wbstall", stall, 0);
      check_eq("long.wbval", src_value[31:0], 32'h55);
      cyc("long.wb");
      check_eq("long.clr", sb_busy[7], 0);

      // Same-cycle set/clear, then full unit.
      issue_long(5'd7, "sc.iss");
      idle();
      dst_addr  = 5'd7;
      dst_we    = 1'b1;
      dst_long  = 1'b1;
      issue     = 1'b1;
      wbl_valid = 1'b1;
      wbl_dest  = 5'd7;
      #1;
      cyc("sc.both");
      check_eq("sc.sb7", sb_busy[7], 1);
      check_eq("sc.cnt", long_cnt, 1);
      issue_long(5'd1, "full.i1");
      issue_long(5'd2, "full.i2");
      issue_long(5'd3, "full.i3");
      idle();
      dst_addr = 5'd9;
      dst_we   = 1'b1;
      dst_long = 1'b1;
      #1;
      check_eq("full.stall", stall, 1);
      cyc("full.stall");
      wbl_valid = 1'b1;
      wbl_dest  = 5'd1;
      #1;
      check_eq("full.wb", stall, 0);
      cyc("full.wb");
      wb_long(5'd2, 32'h2, "drain2");
      wb_long(5'd3, 32'h3, "drain3");
      wb_long(5'd7, 32'h7, "drain7");

      // Flush masks stall and suppresses the set.
      issue_long(5'd10, "fl.iss");
      idle();
      src_addr[4:0] = 5'd10;
      src_used      = 2'b01;
      dst_addr      = 5'd9;
      dst_we        = 1'b1;
      dst_long      = 1'b1;
      issue         = 1'b1;
      flush         = 1'b1;
      #1;
      check_eq("fl.stall", stall, 0);
      cyc("fl.cyc");
      check_eq("fl.cnt", long_cnt, 1);
      check_eq("fl.sb9", sb_busy[9], 0);
      check_eq("fl.sb10", sb_busy[10], 1);
      wb_long(5'd10, 32'hA, "fl.drain");

      // Asynchronous reset mid-operation.
      issue_long(5'd4, "ar.iss");
      idle();
      src_used = 2'b11;
      src_addr = {5'd4, 5'd4};
      #1;
      check_eq("ar.pre.sb", sb_busy, 32'h10);
      check_eq("ar.pre.cnt", long_cnt, 1);
      rst = 1'b1;
      #1;
      check_eq("ar.sb", sb_busy, 0);
      check_eq("ar.cnt", long_cnt, 0);
      check_eq("ar.stall", stall, 0);
      check_eq("ar.val", src_value, {32'h2222_2222, 32'h1111_1111});
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Random traffic.
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < NSRC; i++) begin
            src_addr[i*5 +: 5]  = 5'($urandom_range(7));
            rf_rdata[i*32 +: 32] = $urandom;
         end
         src_used = 2'($urandom);
         for (int k = 0; k < NFWD; k++) begin
            fwd_dest[k*5 +: 5]  = 5'($urandom_range(7));
            fwd_data[k*32 +: 32] = $urandom;
         end
         fwd_valid = 2'($urandom);
         fwd_ready = 2'($urandom) | 2'($urandom);
         dst_addr  = 5'($urandom_range(7));
         dst_we    = 1'($urandom);
         dst_long  = 1'($urandom);
         issue     = 1'($urandom);
         flush     = ($urandom_range(7) == 0);
         wbl_valid = (m_cnt > 0) && (m_q.size() > 0) && ($urandom_range(2) == 0);
         wbl_dest  = wbl_valid ? 5'(m_q[$urandom_range(m_q.size() - 1)]) : 5'($urandom_range(7));
         wbl_data  = $urandom;
         if (issue && !flush && dst_we && dst_long && !wbl_valid && m_cnt == MAX_LONG)
            issue = 1'b0;
         #1;
         cyc("rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
